// File: rtl/execute_stage_v2.sv
// Execute stage with forwarding muxes, 8-op ALU, branch/jump resolution and E/M register.
// Define EXECUTE_MUL_EN to build in the iterative shift-add multiplier that stalls through BusyE.
module execute_stage_v2 #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RegWriteE,
  input  logic               ALUSrcE,
  input  logic               MemWriteE,
  input  logic               ResultSrcE,
  input  logic               BranchE,
  input  logic               JumpE,
  input  logic               MulE,
  input  logic [2:0]         ALUControlE,
  input  logic [1:0]         ForwardAE,
  input  logic [1:0]         ForwardBE,
  input  logic [XLEN-1:0]    RD1E,
  input  logic [XLEN-1:0]    RD2E,
  input  logic [XLEN-1:0]    ImmExtE,
  input  logic [XLEN-1:0]    PCE,
  input  logic [XLEN-1:0]    PCPlus4E,
  input  logic [XLEN-1:0]    ResultW,
  input  logic [RADDR_W-1:0] RS1E,
  input  logic [RADDR_W-1:0] RS2E,
  input  logic [RADDR_W-1:0] RDE,
  output logic               RegWriteM,
  output logic               ResultSrcM,
  output logic               MemWriteM,
  output logic [XLEN-1:0]    ALUResultM,
  output logic [XLEN-1:0]    WriteDataM,
  output logic [XLEN-1:0]    PCPlus4M,
  output logic [RADDR_W-1:0] RDM,
  output logic               PCSrcE,
  output logic [XLEN-1:0]    PCTargetE,
  output logic               BusyE,
  output logic [1:0]         mul_state_dbg
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic [XLEN-1:0] WriteDataE;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] result_e;
  logic            ZeroE;

  // Hazard-unit address fields only pass through this stage.
  logic unused_ok;
  assign unused_ok = ^{RS1E, RS2E, MulE};

  always_comb begin
    SrcAE = RD1E;
    case (ForwardAE)
      2'b01:   SrcAE = ResultW;
      2'b10:   SrcAE = ALUResultM;
      default: SrcAE = RD1E;
    endcase
  end

  always_comb begin
    WriteDataE = RD2E;
    case (ForwardBE)
      2'b01:   WriteDataE = ResultW;
      2'b10:   WriteDataE = ALUResultM;
      default: WriteDataE = RD2E;
    endcase
  end

  assign SrcBE = ALUSrcE ? ImmExtE : WriteDataE;

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      3'b000: alu_result = SrcAE + SrcBE;
      3'b001: alu_result = SrcAE - SrcBE;
      3'b010: alu_result = SrcAE & SrcBE;
      3'b011: alu_result = SrcAE | SrcBE;
      3'b100: alu_result = SrcAE ^ SrcBE;
      3'b101: alu_result = {{(XLEN-1){1'b0}}, ($signed(SrcAE) < $signed(SrcBE))};
      3'b110: alu_result = SrcAE << SrcBE[SHW-1:0];
      3'b111: alu_result = SrcAE >> SrcBE[SHW-1:0];
      default: alu_result = '0;
    endcase
  end

  assign ZeroE     = (alu_result == '0);
  assign PCSrcE    = JumpE | (BranchE & ZeroE);
  assign PCTargetE = PCE + ImmExtE;

`ifdef EXECUTE_MUL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int CNT_W = $clog2(XLEN + 1);

  mul_state_t       state, state_nx;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  mcand;
  logic [XLEN-1:0]  mplier;
  logic [XLEN-1:0]  acc;

  // DONE always returns to IDLE so a still-held MulE does not restart the same instruction.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (MulE) state_nx = RUN;
      RUN:     if (count == CNT_W'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Operands are latched on entry because forward sources keep moving during the stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      case (state)
        IDLE: if (MulE) begin
          mcand  <= SrcAE;
          mplier <= SrcBE;
          acc    <= '0;
          count  <= CNT_W'(XLEN);
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign BusyE         = rst & (((state == IDLE) & MulE) | (state == RUN));
  assign result_e      = (state == DONE) ? acc : alu_result;
  assign mul_state_dbg = state;
`else
  assign BusyE         = 1'b0;
  assign result_e      = alu_result;
  assign mul_state_dbg = 2'b00;
`endif

  // A stalled cycle sends a fully cleared bubble into M.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RDM        <= '0;
    end else if (BusyE) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RDM        <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE;
      ALUResultM <= result_e;
      WriteDataM <= WriteDataE;
      PCPlus4M   <= PCPlus4E;
      RDM        <= RDE;
    end
  end

endmodule

// File: tb/tb_execute_stage_v2.sv
// Scoreboard bench for execute_stage_v2: drivers push expected M-stage words, a monitor pops them.
// Multiplier scenarios are compiled only when EXECUTE_MUL_EN is defined.
module tb_execute_stage_v2;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int EW   = 3 * XLEN + RW;

  logic            clk;
  logic            rst;
  logic            RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE, MulE;
  logic [2:0]      ALUControlE;
  logic [1:0]      ForwardAE, ForwardBE;
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
  logic [RW-1:0]   RS1E, RS2E, RDE;
  logic            RegWriteM, ResultSrcM, MemWriteM;
  logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [RW-1:0]   RDM;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            BusyE;
  logic [1:0]      mul_state_dbg;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [RW-1:0]   rd_ctr  = 5'd1;
  logic [XLEN-1:0] pc4_ctr = 32'h0000_1004;

  execute_stage_v2 #(.XLEN(XLEN), .RADDR_W(RW)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE), .MulE(MulE),
    .ALUControlE(ALUControlE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ResultW(ResultW), .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RDM(RDM),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE), .mul_state_dbg(mul_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor: every valid M-stage word is matched against the scoreboard
  always @(negedge clk) begin
    if (rst && RegWriteM) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL m_unexpected: got %0h expected none", ALUResultM);
      end else begin
        check("m_out", {ALUResultM, WriteDataM, PCPlus4M, RDM}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic push_exp(input logic [XLEN-1:0] e_alu, input logic [XLEN-1:0] e_wd);
    RDE      = rd_ctr;
    PCPlus4E = pc4_ctr;
    exp_q.push_back({e_alu, e_wd, pc4_ctr, rd_ctr});
    rd_ctr   = rd_ctr + 5'd1;
    pc4_ctr  = pc4_ctr + 32'd4;
  endtask

  task automatic drive(input logic [2:0] op, input logic src, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] imm, input logic [XLEN-1:0] e_alu,
                       input logic [XLEN-1:0] e_wd);
    ALUControlE = op;
    ALUSrcE     = src;
    ForwardAE   = fa;
    ForwardBE   = fb;
    RD1E        = a;
    RD2E        = b;
    ImmExtE     = imm;
    RegWriteE   = 1'b1;
    push_exp(e_alu, e_wd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWriteE  = 1'b0;
    MemWriteE  = 1'b0;
    ResultSrcE = 1'b0;
    MulE       = 1'b0;
    BranchE    = 1'b0;
    JumpE      = 1'b0;
    step();
  endtask

`ifdef EXECUTE_MUL_EN
  task automatic mul_measure(input string name, input bit wiggle);
    int busy = 0;
    int bub  = 0;
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (wiggle && i == 5) ResultW = 32'h0000_0099;
      if (i > 0 && !RegWriteM && ALUResultM == '0) bub++;
      if (!BusyE) done = 1'b1;
      else busy++;
    end
    check({name, "_busy_cycles"}, busy, 33);
    check({name, "_bubbles"}, bub, 33);
    @(posedge clk);
    #1;
    MulE      = 1'b0;
    RegWriteE = 1'b0;
  endtask

  task automatic mul_set(input logic [1:0] fa, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    ALUControlE = 3'b000;
    ALUSrcE     = 1'b0;
    ForwardAE   = fa;
    ForwardBE   = 2'b00;
    RD1E        = a;
    RD2E        = b;
    RegWriteE   = 1'b1;
    MulE        = 1'b1;
  endtask
`endif

  // stimulus
  initial begin
    rst = 1'b0;
    {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE, MulE} = '0;
    ALUControlE = '0; ForwardAE = '0; ForwardBE = '0;
    RD1E = '0; RD2E = '0; ImmExtE = '0; PCE = '0; PCPlus4E = '0; ResultW = '0;
    RS1E = 5'd3; RS2E = 5'd4; RDE = '0;
    #2;
    check("reset_m_outputs", {RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, PCPlus4M, RDM}, '0);
    check("reset_busy_state", {BusyE, mul_state_dbg}, 3'b000);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // ALU sweep: RD1E=1, RD2E=2
    drive(3'b000, 1'b0, 2'b00, 2'b00, 32'd1, 32'd2, '0, 32'h0000_0003, 32'd2); step();
    drive(3'b001, 1'b0, 2'b00, 2'b00, 32'd1, 32'd2, '0, 32'hFFFF_FFFF, 32'd2); step();
    drive(3'b010, 1'b0, 2'b00, 2'b00, 32'd1, 32'd2, '0, 32'h0000_0000, 32'd2); step();
    drive(3'b011, 1'b0, 2'b00, 2'b00, 32'd1, 32'd2, '0, 32'h0000_0003, 32'd2); step();
    drive(3'b100, 1'b0, 2'b00, 2'b00, 32'd1, 32'd2, '0, 32'h0000_0003, 32'd2); step();
    drive(3'b101, 1'b0, 2'b00, 2'b00, 32'd1, 32'd2, '0, 32'h0000_0001, 32'd2); step();
    drive(3'b110, 1'b0, 2'b00, 2'b00, 32'd1, 32'd2, '0, 32'h0000_0004, 32'd2); step();
    drive(3'b111, 1'b0, 2'b00, 2'b00, 32'd1, 32'd2, '0, 32'h0000_0000, 32'd2); step();
    drive(3'b101, 1'b0, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd2, '0, 32'h0000_0001, 32'd2); step();
    // immediate operand: 0x10 >> imm 4
    drive(3'b111, 1'b1, 2'b00, 2'b00, 32'h10, 32'd9, 32'd4, 32'h0000_0001, 32'd9); step();

    // branch / jump
    BranchE = 1'b1;
    drive(3'b001, 1'b0, 2'b00, 2'b00, 32'hA, 32'hA, '0, 32'h0, 32'hA);
    #1 check("branch_taken", PCSrcE, 1'b1);
    step();
    drive(3'b001, 1'b0, 2'b00, 2'b00, 32'hA, 32'hB, '0, 32'hFFFF_FFFF, 32'hB);
    #1 check("branch_not_taken", PCSrcE, 1'b0);
    step();
    BranchE = 1'b0;
    JumpE   = 1'b1;
    drive(3'b001, 1'b0, 2'b00, 2'b00, 32'hA, 32'hB, '0, 32'hFFFF_FFFF, 32'hB);
    #1 check("jump", PCSrcE, 1'b1);
    step();
    JumpE = 1'b0;
    PCE   = 32'hFFFF_FFFF;
    drive(3'b000, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 32'hF, 32'h0, 32'h0);
    #1 check("pc_target_wrap", PCTargetE, 32'h0000_000E);
    step();

    // forwarding
    ResultW = 32'h55;
    drive(3'b000, 1'b0, 2'b01, 2'b00, 32'h0, 32'd1, '0, 32'h56, 32'd1); step();
    drive(3'b000, 1'b0, 2'b00, 2'b10, 32'd1, 32'd0, '0, 32'h57, 32'h56); step();
    idle();

    // asynchronous reset mid-run, then control pass-through
    drive(3'b011, 1'b0, 2'b00, 2'b00, 32'hF0, 32'h0F, '0, 32'hFF, 32'h0F); step();
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check("async_reset_m", {RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, PCPlus4M, RDM}, '0);
    #1 rst = 1'b1;
    MemWriteE  = 1'b1;
    ResultSrcE = 1'b1;
    drive(3'b000, 1'b0, 2'b00, 2'b00, 32'd2, 32'd3, '0, 32'd5, 32'd3);
    step();
    check("ctrl_after_reset", {RegWriteM, MemWriteM, ResultSrcM}, 3'b111);
    idle();

`ifdef EXECUTE_MUL_EN
    mul_set(2'b00, 32'd7, 32'd6);
    push_exp(32'h2A, 32'd6);
    mul_measure("mul_7x6", 1'b0);
    mul_set(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_exp(32'h1, 32'hFFFF_FFFF);
    mul_measure("mul_ones", 1'b0);
    ResultW = 32'd3;
    mul_set(2'b01, 32'd0, 32'd5);
    push_exp(32'hF, 32'd5);
    mul_measure("mul_fwd_latch", 1'b1);
    idle();

    // abort part way through RUN, restart with MulE still held
    mul_set(2'b00, 32'd9, 32'd3);
    repeat (11) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("abort_busy_state", {BusyE, mul_state_dbg}, 3'b000);
    check("abort_m_outputs", {RegWriteM, ALUResultM, RDM}, '0);
    #1 rst = 1'b1;
    push_exp(32'd27, 32'd3);
    mul_measure("mul_restart", 1'b0);
    idle();
`else
    MulE = 1'b1;
    drive(3'b000, 1'b0, 2'b00, 2'b00, 32'd7, 32'd6, '0, 32'h0000_000D, 32'd6);
    #1 check("mul_disabled_busy", BusyE, 1'b0);
    step();
    idle();
`endif

    idle();
    idle();
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
